// File: rtl/ps2_key_decoder_if.sv
// Decoded key-event bundle from the PS/2 receiver to the game processor.
// Strobes are single-cycle; no backpressure (the consumer must sample on key_valid).
interface ps2_key_decoder_if;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  modport master (output keycode, key_make, key_ext, key_valid, frame_err);
  modport slave  (input  keycode, key_make, key_ext, key_valid, frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 receiver; key_valid/frame_err 1 clk after the stop-bit fall event, no backpressure.
// Optional PS2_PARITY_CHECK_EN: enables odd-parity checking of each frame.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_key_decoder_if.master  key
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] hist;
  logic                  filt, filt_prev, fall;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [7:0]            shreg, shreg_nxt;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_hit;
  logic                  frame_good;
  logic                  byte_done, byte_bad, start_bad;
  logic                  ext_pend, brk_pend;
`ifdef PS2_PARITY_CHECK_EN
  logic                  par_bit, par_nxt;
`endif

  // Lines idle high, so the synchronizers and filter come out of reset at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      hist      <= '1;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_dat;
      dat_s2    <= dat_s1;
      hist      <= {hist[FILTER_LEN-2:0], clk_s2};
      if (&hist)
        filt <= 1'b1;
      else if (~|hist)
        filt <= 1'b0;
      filt_prev <= filt;
    end
  end

  assign fall    = filt_prev & ~filt;
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = dat_s2 & (^shreg ^ par_bit);
`else
  assign frame_good = dat_s2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tmo_cnt <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
`ifdef PS2_PARITY_CHECK_EN
      par_bit <= par_nxt;
`endif
      // Saturating idle-time counter, only meaningful inside a frame.
      if (fall || state == IDLE)
        tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
`ifdef PS2_PARITY_CHECK_EN
    par_nxt     = par_bit;
`endif
    byte_done   = 1'b0;
    byte_bad    = 1'b0;
    start_bad   = 1'b0;
    if (tmo_hit) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            start_bad = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt   = {dat_s2, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_nxt = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_nxt   = dat_s2;
`endif
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (frame_good)
            byte_done = 1'b1;
          else
            byte_bad = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Prefix folding and output registers; timeout leaves pending prefixes alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key.keycode   <= 8'h00;
      key.key_make  <= 1'b0;
      key.key_ext   <= 1'b0;
      key.key_valid <= 1'b0;
      key.frame_err <= 1'b0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
    end else begin
      key.key_valid <= 1'b0;
      key.frame_err <= start_bad | byte_bad | tmo_hit;
      if (byte_bad) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_done) begin
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (shreg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else begin
          key.keycode   <= shreg;
          key.key_make  <= ~brk_pend;
          key.key_ext   <= ext_pend;
          key.key_valid <= 1'b1;
          ext_pend      <= 1'b0;
          brk_pend      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus a randomized
// byte stream scored against a prefix-folding reference model.
module tb_ps2_key_decoder;
  localparam int L    = 4;
  localparam int TMO  = 300;
  localparam int HALF = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_key_decoder_if kif();

  ps2_key_decoder #(.FILTER_LEN(L), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .key     (kif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int last_valid_cyc = 0;
  int fall_cyc = 0;
  logic [9:0] obs_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (kif.key_valid) begin
        n_valid++;
        obs_q.push_back({kif.keycode, kif.key_make, kif.key_ext});
        last_valid_cyc = cyc;
      end
      if (kif.frame_err) n_err++;
      if (kif.key_valid && kif.frame_err) n_both++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(L + 4);
      ps2_clk = 1'b0;
      wait_cyc(L - 2);
      ps2_clk = 1'b1;
      wait_cyc(HALF - (L + 4) - (L - 2));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit bad_stop, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ flip, glitch);
    ps2_bit(!bad_stop, glitch);
    ps2_dat = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(5);
    checks++; if (kif.keycode !== 8'h00) begin errors++; $display("FAIL reset_keycode got %h want 00", kif.keycode); end
    checks++; if (kif.key_make !== 1'b0) begin errors++; $display("FAIL reset_make got %b want 0", kif.key_make); end
    checks++; if (kif.key_ext !== 1'b0) begin errors++; $display("FAIL reset_ext got %b want 0", kif.key_ext); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", kif.key_valid); end
    checks++; if (kif.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", kif.frame_err); end
    rst_n = 1'b1;
    wait_cyc(30);
    checks++; if (n_valid + n_err !== 0) begin errors++; $display("FAIL reset_idle_pulses got %0d want 0", n_valid + n_err); end
  endtask

  task automatic test_make();
    int v0 = n_valid, e0 = n_err, lat;
    send_frame(8'h1C, 0, 0, 0);
    lat = last_valid_cyc - fall_cyc;
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL make_count got %0d want 1", n_valid - v0); end
    checks++; if (n_err !== e0) begin errors++; $display("FAIL make_err got %0d want %0d", n_err, e0); end
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h1C, 1'b1, 1'b0})
      begin errors++; $display("FAIL make_event got %h/%b/%b want 1c/1/0", kif.keycode, kif.key_make, kif.key_ext); end
    checks++; if (lat < L + 2 || lat > L + 6) begin errors++; $display("FAIL make_latency got %0d want %0d..%0d", lat, L + 2, L + 6); end
  endtask

  task automatic test_break();
    int v0 = n_valid;
    send_frame(8'hF0, 0, 0, 0);
    checks++; if (n_valid !== v0) begin errors++; $display("FAIL break_prefix_silent got %0d want %0d", n_valid, v0); end
    send_frame(8'h1C, 0, 0, 0);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL break_count got %0d want 1", n_valid - v0); end
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h1C, 1'b0, 1'b0})
      begin errors++; $display("FAIL break_event got %h/%b/%b want 1c/0/0", kif.keycode, kif.key_make, kif.key_ext); end
  endtask

  task automatic test_ext();
    int v0 = n_valid;
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL ext_count got %0d want 1", n_valid - v0); end
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h75, 1'b0, 1'b1})
      begin errors++; $display("FAIL ext_break_event got %h/%b/%b want 75/0/1", kif.keycode, kif.key_make, kif.key_ext); end
    send_frame(8'h75, 0, 0, 0);
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h75, 1'b1, 1'b0})
      begin errors++; $display("FAIL ext_flags_cleared got %h/%b/%b want 75/1/0", kif.keycode, kif.key_make, kif.key_ext); end
  endtask

  task automatic test_parity();
    int v0 = n_valid, e0 = n_err;
    send_frame(8'h1C, 1, 0, 0);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL parity_err got %0d want 1", n_err - e0); end
    checks++; if (n_valid !== v0) begin errors++; $display("FAIL parity_novalid got %0d want %0d", n_valid, v0); end
    checks++; if (kif.keycode !== 8'h75) begin errors++; $display("FAIL parity_hold got %h want 75", kif.keycode); end
`else
    checks++; if (n_err !== e0) begin errors++; $display("FAIL parity_ignored_err got %0d want %0d", n_err, e0); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL parity_ignored_valid got %0d want 1", n_valid - v0); end
    checks++; if (kif.keycode !== 8'h1C) begin errors++; $display("FAIL parity_ignored_code got %h want 1c", kif.keycode); end
`endif
  endtask

  task automatic test_timeout();
    int v0, e0;
    send_frame(8'hE0, 0, 0, 0);
    v0 = n_valid; e0 = n_err;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 0);
    wait_cyc(TMO + 60);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL timeout_err got %0d want 1", n_err - e0); end
    checks++; if (n_valid !== v0) begin errors++; $display("FAIL timeout_novalid got %0d want %0d", n_valid, v0); end
    send_frame(8'h29, 0, 0, 0);
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h29, 1'b1, 1'b1})
      begin errors++; $display("FAIL timeout_recover got %h/%b/%b want 29/1/1", kif.keycode, kif.key_make, kif.key_ext); end
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL timeout_single got %0d want 1", n_err - e0); end
  endtask

  task automatic test_glitch();
    int v0 = n_valid, e0 = n_err;
    send_frame(8'h1C, 0, 0, 1);
    checks++; if (n_valid - v0 !== 1 || n_err !== e0)
      begin errors++; $display("FAIL glitch_pulses got valid=%0d err=%0d want 1/0", n_valid - v0, n_err - e0); end
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h1C, 1'b1, 1'b0})
      begin errors++; $display("FAIL glitch_event got %h/%b/%b want 1c/1/0", kif.keycode, kif.key_make, kif.key_ext); end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    send_frame(8'hE0, 0, 0, 0);
    v0 = n_valid; e0 = n_err;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0);
    rst_n = 1'b0;
    #1;
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext, kif.key_valid, kif.frame_err} !== 12'h000)
      begin errors++; $display("FAIL midreset_outputs got %h want 000", {kif.keycode, kif.key_make, kif.key_ext, kif.key_valid, kif.frame_err}); end
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(TMO + 40);
    checks++; if (n_valid !== v0 || n_err !== e0)
      begin errors++; $display("FAIL midreset_pulses got valid=%0d err=%0d want 0/0", n_valid - v0, n_err - e0); end
    send_frame(8'h1C, 0, 0, 0);
    checks++; if ({kif.keycode, kif.key_make, kif.key_ext} !== {8'h1C, 1'b1, 1'b0})
      begin errors++; $display("FAIL midreset_prefix_dropped got %h/%b/%b want 1c/1/0", kif.keycode, kif.key_make, kif.key_ext); end
  endtask

  task automatic test_random();
    logic [9:0] exp_q[$];
    logic [7:0] b;
    bit m_ext = 0, m_brk = 0, flip, bstop, good;
    int exp_err = 0, e0 = n_err, sel;
    obs_q.delete();
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 5 && !m_ext && !m_brk) begin
        ps2_bit(1'b1, 0);
        wait_cyc(3 * HALF);
        exp_err++;
        continue;
      end
      if (sel < 30)      b = 8'hE0;
      else if (sel < 45) b = 8'hF0;
      else if (sel < 52) b = 8'hFA;
      else               b = 8'($urandom);
      flip  = ($urandom_range(0, 9) == 0);
      bstop = ($urandom_range(0, 9) == 0);
      send_frame(b, flip, bstop, 0);
`ifdef PS2_PARITY_CHECK_EN
      good = !bstop && !flip;
`else
      good = !bstop;
`endif
      if (!good) begin
        exp_err++; m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
        m_ext = 0; m_brk = 0;
      end else begin
        exp_q.push_back({b, !m_brk, m_ext});
        m_ext = 0; m_brk = 0;
      end
    end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (n_err - e0 !== exp_err) begin errors++; $display("FAIL rand_errs got %0d want %0d", n_err - e0, exp_err); end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL exclusive_strobes got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
